// File: rtl/imem_dmem_bus_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | imem_dmem_bus_arbiter_pkg: shared widths, FSM and grant encodings         |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package imem_dmem_bus_arbiter_pkg;

  // Defaults track the imem_line / dmem_line width and the system bus width.
  localparam int unsigned LINE_W_DEF = 512;
  localparam int unsigned BUS_W_DEF  = 64;
  localparam int unsigned ADDR_W     = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  function automatic int unsigned beat_cnt_w(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_dmem_bus_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | imem_dmem_bus_arbiter_if: imem, dmem and system-bus signals of the arbiter|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface imem_dmem_bus_arbiter_if
  import imem_dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned BUS_W  = BUS_W_DEF
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_rd;
  logic [LINE_W-1:0] i_data;
  logic              i_dv;

  logic [ADDR_W-1:0] d_addr;
  logic              d_rd;
  logic              d_wr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_data;
  logic              d_dv;

  logic [ADDR_W-1:0] m_addr;
  logic              m_rd;
  logic              m_wr;
  logic [BUS_W-1:0]  m_wdata;
  logic [BUS_W-1:0]  m_rdata;
  logic              m_ack;

  // master: the arbiter itself; slave: the caches and the memory bus around it
  modport master (
    input  i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_ack,
    output i_data, i_dv, d_data, d_dv, m_addr, m_rd, m_wr, m_wdata
  );

  modport slave (
    output i_addr, i_rd, d_addr, d_rd, d_wr, d_wdata, m_rdata, m_ack,
    input  i_data, i_dv, d_data, d_dv, m_addr, m_rd, m_wr, m_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_dmem_bus_arbiter_bus_line_buffer.sv
// +--------------------------------------------------------------------------+
// | bus_line_buffer: cache-line register with beat-sliced capture and read   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module bus_line_buffer
  import imem_dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned BUS_W  = BUS_W_DEF,
  parameter int unsigned BEAT_W = beat_cnt_w(LINE_W / BUS_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              capture,
  input  logic [BEAT_W-1:0] beat,
  input  logic [LINE_W-1:0] load_data,
  input  logic [BUS_W-1:0]  beat_wdata,
  output logic [LINE_W-1:0] line,
  output logic [BUS_W-1:0]  beat_rdata
);
  localparam int unsigned BEATS = LINE_W / BUS_W;

  logic [BEATS-1:0][BUS_W-1:0] line_q, line_d;

  // A parallel load (write-back entry) wins over any beat capture.
  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d = load_data;
    end else if (capture) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat == BEAT_W'(k)) begin
          line_d[k] = beat_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line       = line_q;
  assign beat_rdata = line_q[beat];

endmodule

`default_nettype wire

// File: rtl/imem_dmem_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | imem_dmem_bus_arbiter: round-robin imem/dmem line refill and write-back   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_dmem_bus_arbiter
  import imem_dmem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned BUS_W  = BUS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imem_dmem_bus_arbiter_if.master bus
);
  localparam int unsigned BEATS   = LINE_W / BUS_W;
  localparam int unsigned OFFS_W  = $clog2(LINE_W / 8);
  localparam int unsigned BEAT_W  = beat_cnt_w(BEATS);
  localparam int unsigned BYTE_SH = $clog2(BUS_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = (64'd1 << OFFS_W) - 64'd1;

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  grant_e            pick;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] sel_addr;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              i_cand, d_cand;
  logic              buf_load, buf_capture;
  logic [LINE_W-1:0] buf_line;
  logic [BUS_W-1:0]  buf_beat_rdata;

  // last_grant_q doubles as the owner of the burst in flight.
  always_comb begin
    i_cand = bus.i_rd;
    d_cand = bus.d_rd | bus.d_wr;
    if (i_cand && d_cand) begin
      pick = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (i_cand) begin
      pick = GRANT_I;
    end else begin
      pick = GRANT_D;
    end
    sel_addr = (pick == GRANT_I) ? bus.i_addr : bus.d_addr;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    beat_d       = beat_q;
    buf_load     = 1'b0;
    buf_capture  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cand || d_cand) begin
          last_grant_d = pick;
          base_d       = sel_addr & ~LINE_MASK;
          beat_d       = '0;
          if ((pick == GRANT_D) && bus.d_wr) begin
            state_d  = ST_WR_BURST;
            buf_load = 1'b1;
          end else begin
            state_d  = ST_RD_BURST;
          end
        end
      end
      ST_RD_BURST: begin
        if (bus.m_ack) begin
          buf_capture = 1'b1;
          beat_d      = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_WR_BURST: begin
        if (bus.m_ack) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_D;
      base_q       <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      beat_q       <= beat_d;
    end
  end

  bus_line_buffer #(
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W),
    .BEAT_W (BEAT_W)
  ) u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .capture    (buf_capture),
    .beat       (beat_q),
    .load_data  (bus.d_wdata),
    .beat_wdata (bus.m_rdata),
    .line       (buf_line),
    .beat_rdata (buf_beat_rdata)
  );

  // Bus-facing outputs decode straight from the flops so an async reset clears them at once.
  always_comb begin
    bus.m_rd    = (state_q == ST_RD_BURST);
    bus.m_wr    = (state_q == ST_WR_BURST);
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if ((state_q == ST_RD_BURST) || (state_q == ST_WR_BURST)) begin
      bus.m_addr = base_q + (ADDR_W'(beat_q) << BYTE_SH);
    end
    if (state_q == ST_WR_BURST) begin
      bus.m_wdata = buf_beat_rdata;
    end
    bus.i_dv = (state_q == ST_DONE) && (last_grant_q == GRANT_I);
    bus.d_dv = (state_q == ST_DONE) && (last_grant_q == GRANT_D);
  end

  assign bus.i_data = buf_line;
  assign bus.d_data = buf_line;

endmodule

`default_nettype wire

// File: tb/tb_imem_dmem_bus_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_imem_dmem_bus_arbiter: scoreboard bench with transaction-level model   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imem_dmem_bus_arbiter;
  localparam int LW = 512;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_dmem_bus_arbiter_if #(.LINE_W(LW), .BUS_W(BW)) bus ();
  imem_dmem_bus_arbiter #(.LINE_W(LW), .BUS_W(BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ack_mode = 0;

  // requester-side model state
  logic          i_busy = 1'b0, d_busy = 1'b0, d_isw = 1'b0;
  int            i_rc = 0, d_rc = 0;
  logic [63:0]   i_base = '0, d_base = '0;
  logic [LW-1:0] d_wl = '0;
  logic [LW-1:0] iq[$];
  logic [LW-1:0] dq[$];

  // bus-side model state
  logic          in_b = 1'b0, dv_due = 1'b0, idle_due = 1'b0;
  logic          b_who = 1'b0, b_wr = 1'b0, dv_who = 1'b0, last_m = 1'b1;
  logic [63:0]   b_base = '0;
  logic [LW-1:0] b_wl = '0, mbuf = '0;
  int            b_beat = 0;

  function automatic void chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] mem_word(logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h1357_9BDF};
  endfunction

  function automatic logic [LW-1:0] rd_line(logic [63:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = mem_word(base + 64'(k * 8));
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder: ack pattern chosen by the stimulus phase
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0:       bus.m_ack = 1'b1;
      1:       bus.m_ack = (cyc % 3 == 0);
      default: bus.m_ack = 1'($urandom_range(0, 1));
    endcase
    bus.m_rdata = mem_word(bus.m_addr);
  end

  // monitor: predicts grant order, beat addresses and data, pops scoreboard on dv
  always @(negedge clk) begin : mon
    logic sr, ci, cd;
    sr = bus.m_rd | bus.m_wr;
    if (!rst_n) begin
      in_b = 1'b0; dv_due = 1'b0; idle_due = 1'b0; last_m = 1'b1; mbuf = '0;
    end else if (dv_due) begin
      chk("i_dv_at_done", bus.i_dv, dv_who == 1'b0);
      chk("d_dv_at_done", bus.d_dv, dv_who == 1'b1);
      chk("strobe_at_done", sr, 0);
      if (dv_who == 1'b0) begin
        chk("i_queue_nonempty", iq.size() != 0, 1);
        if (iq.size() != 0) mbuf = iq.pop_front();
      end else begin
        chk("d_queue_nonempty", dq.size() != 0, 1);
        if (dq.size() != 0) mbuf = dq.pop_front();
      end
      chk("i_data_line", bus.i_data, mbuf);
      chk("d_data_line", bus.d_data, mbuf);
      dv_due = 1'b0;
      idle_due = 1'b1;
    end else begin
      chk("dv_outside_done", {bus.i_dv, bus.d_dv}, 0);
      chk("both_strobes", bus.m_rd & bus.m_wr, 0);
      if (idle_due) begin
        chk("idle_after_done", sr, 0);
        idle_due = 1'b0;
      end else if (!in_b && sr) begin
        ci = i_busy && (i_rc < cyc);
        cd = d_busy && (d_rc < cyc);
        chk("burst_has_requester", ci | cd, 1);
        if (ci && cd) b_who = ~last_m;
        else          b_who = cd;
        last_m = b_who;
        b_wr   = b_who && d_isw;
        b_base = b_who ? d_base : i_base;
        b_wl   = d_wl;
        b_beat = 0;
        in_b   = 1'b1;
      end
      if (in_b) begin
        chk("m_rd_level", bus.m_rd, !b_wr);
        chk("m_wr_level", bus.m_wr, b_wr);
        chk("m_addr_beat", bus.m_addr, b_base + 64'(b_beat * 8));
        if (b_wr) chk("m_wdata_beat", bus.m_wdata, b_wl[b_beat*BW +: BW]);
        if (bus.m_ack) begin
          b_beat++;
          if (b_beat == NB) begin
            in_b = 1'b0; dv_due = 1'b1; dv_who = b_who;
          end
        end
      end else begin
        chk("buffer_held", bus.i_data, mbuf);
      end
    end
  end

  // bounded wait for the requester's dv; scrambles its inputs while its burst runs
  task automatic wait_dv(input logic who);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      seen = who ? bus.d_dv : bus.i_dv;
      if (!seen && in_b && (b_who == who)) begin
        if (who) begin bus.d_addr = {$urandom, $urandom}; bus.d_wdata = rand_line(); end
        else     bus.i_addr = {$urandom, $urandom};
      end
    end
    if (!seen) chk(who ? "d_dv_timeout" : "i_dv_timeout", 0, 1);
  endtask

  task automatic i_txn(input logic [63:0] a);
    @(posedge clk); #1;
    i_base = a & ~64'h3F;
    iq.push_back(rd_line(i_base));
    bus.i_addr = a; bus.i_rd = 1'b1; i_rc = cyc; i_busy = 1'b1;
    wait_dv(1'b0);
    @(posedge clk); #1;
    bus.i_rd = 1'b0; i_busy = 1'b0;
  endtask

  // kind: 0 read, 1 write-back, 2 write-back with d_rd also held
  task automatic d_txn(input int kind, input logic [63:0] a, input logic [LW-1:0] wl);
    @(posedge clk); #1;
    d_base = a & ~64'h3F; d_wl = wl; d_isw = (kind != 0);
    if (kind != 0) dq.push_back(wl);
    if (kind != 1) dq.push_back(rd_line(d_base));
    bus.d_addr = a; bus.d_wdata = wl;
    bus.d_wr = (kind != 0); bus.d_rd = (kind != 1);
    d_rc = cyc; d_busy = 1'b1;
    wait_dv(1'b1);
    if (kind == 2) begin
      @(posedge clk); #1;
      bus.d_wr = 1'b0; d_isw = 1'b0; bus.d_addr = a;
      wait_dv(1'b1);
    end
    @(posedge clk); #1;
    bus.d_rd = 1'b0; bus.d_wr = 1'b0; d_busy = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] wb;
    int n;
    bus.i_addr = '0; bus.i_rd = 1'b0; bus.d_addr = '0; bus.d_rd = 1'b0;
    bus.d_wr = 1'b0; bus.d_wdata = '0; bus.m_rdata = '0; bus.m_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_rd", bus.m_rd, 0);
    chk("rst_m_wr", bus.m_wr, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_i_dv", bus.i_dv, 0);
    chk("rst_d_dv", bus.d_dv, 0);
    chk("rst_i_data", bus.i_data, 0);
    chk("rst_d_data", bus.d_data, 0);
    @(negedge clk); rst_n = 1'b1;

    // tie right after reset, then imem re-requests while dmem is still waiting
    ack_mode = 0;
    fork
      begin i_txn(64'h8000_1000); i_txn(64'h8000_2040); end
      d_txn(0, 64'h2000_0000, '0);
    join

    i_txn(64'h8000_0044);

    for (int k = 0; k < NB; k++) wb[k*BW +: BW] = 64'(8'hA0 + k);
    d_txn(2, 64'h1000, wb);

    ack_mode = 1;
    i_txn(64'h8000_0200);
    ack_mode = 0;

    // async reset in the middle of an imem burst
    @(posedge clk); #1;
    i_base = 64'h4000_0000; iq.push_back(rd_line(i_base));
    bus.i_addr = 64'h4000_0008; bus.i_rd = 1'b1; i_rc = cyc; i_busy = 1'b1;
    n = 0;
    while (!(in_b && b_beat >= 4) && n < 200) begin @(negedge clk); n++; end
    chk("mid_burst_reached", n < 200, 1);
    @(posedge clk); #2;
    chk("pre_rst_m_rd", bus.m_rd, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_m_rd", bus.m_rd, 0);
    chk("async_rst_i_dv", bus.i_dv, 0);
    chk("async_rst_m_addr", bus.m_addr, 0);
    bus.i_rd = 1'b0; i_busy = 1'b0; iq.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_strobe", bus.m_rd | bus.m_wr, 0);
    chk("post_rst_line_cleared", bus.i_data, 0);
    i_txn(64'h4000_0008);

    // spurious acks with nobody requesting
    repeat (10) @(negedge clk);
    chk("spurious_no_strobe", bus.m_rd | bus.m_wr, 0);

    ack_mode = 2;
    fork
      for (int t = 0; t < 12; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        i_txn({$urandom, $urandom});
      end
      for (int t = 0; t < 12; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        d_txn(int'($urandom_range(0, 2)), {$urandom, $urandom}, rand_line());
      end
    join
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", iq.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
